// File: rtl/sodor_imm_instr_gen.sv
// sodor_imm_instr_gen
//   Stimulus stage for the Sodor 5-stage verification wrapper. Emits a bounded
//   stream of pseudo-random RV32I register-immediate ALU instructions taken from
//   a 32-bit Galois LFSR, and the canonical NOP (addi x0,x0,0) whenever idle,
//   stalled at reset or finished.
//
// Parameters
//   SEED        initial LFSR state (0 is replaced by 1, the LFSR would lock up)
//   NUM_INSTRS  instructions issued per run (0 is legal)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a run; sampled in idle and done
//   stall        consumer hold; freezes the run while asserted
//   instr        instruction word to the core / ISA model
//   instr_valid  high while instr carries a generated instruction
//   done         high once NUM_INSTRS instructions have been issued
//   count        instructions issued in the current run
module sodor_imm_instr_gen #(
    parameter logic [31:0] SEED       = 32'h0000_0230,
    parameter int unsigned NUM_INSTRS = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        done,
    output logic [31:0] count
);

    localparam logic [31:0] SeedEff   = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] LfsrMask  = 32'h8020_0003;
    localparam logic [31:0] Nop       = 32'h0000_0013;
    localparam logic [31:0] NumInstrs = 32'(NUM_INSTRS);
    localparam logic [6:0]  OpImm     = 7'b0010011;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] lfsr_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        done_q;
    logic [31:0] count_q;

    logic [31:0] lfsr_next;
    logic [11:0] imm;
    logic [31:0] enc;

    // Galois right-shift LFSR step.
    always_comb begin
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 32'h0);
    end

    // Encode the current LFSR state. Shift immediates are legalised so that
    // SLLI/SRLI/SRAI carry only a 5-bit shamt (plus the SRAI bit for funct3=5).
    always_comb begin
        imm = lfsr_q[31:20];
        if (lfsr_q[14:12] == 3'd5) begin
            imm = imm & 12'h41F;
        end else if (lfsr_q[14:12] == 3'd1) begin
            imm = imm & 12'h01F;
        end
        // rs1, funct3 and rd come straight from lfsr[19:7].
        enc = {imm, lfsr_q[19:7], OpImm};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            instr_q <= Nop;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 32'h0;
        end else begin
            unique case (state_q)
                // Done behaves like idle for start; the LFSR is never reseeded so a
                // restart continues the sequence.
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        count_q <= 32'h0;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        if (count_q < NumInstrs) begin
                            instr_q <= enc;
                            valid_q <= 1'b1;
                            lfsr_q  <= lfsr_next;
                            count_q <= count_q + 32'h1;
                        end else begin
                            instr_q <= Nop;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign count       = count_q;

endmodule

// File: tb/tb_sodor_imm_instr_gen.sv
module tb_sodor_imm_instr_gen;

    localparam int unsigned NI      = 3;
    localparam int          SEQ_LEN = 1024;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_a, stall_a, start_b, start_c;
    logic [31:0] instr_a, instr_b, instr_c;
    logic [31:0] count_a, count_b, count_c;
    logic        valid_a, valid_b, valid_c;
    logic        done_a, done_b, done_c;

    sodor_imm_instr_gen #(.SEED(32'h0000_0001), .NUM_INSTRS(NI)) dut (
        .clk(clk), .reset_n(reset_n), .start(start_a), .stall(stall_a),
        .instr(instr_a), .instr_valid(valid_a), .done(done_a), .count(count_a)
    );

    sodor_imm_instr_gen #(.SEED(32'hFFFF_5FFF), .NUM_INSTRS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .stall(1'b0),
        .instr(instr_b), .instr_valid(valid_b), .done(done_b), .count(count_b)
    );

    sodor_imm_instr_gen #(.SEED(32'h0), .NUM_INSTRS(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .stall(1'b0),
        .instr(instr_c), .instr_valid(valid_c), .done(done_c), .count(count_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the instruction stream is just the sequence of encoded LFSR
    // states, indexed globally across restarts.
    function automatic logic [31:0] ref_lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ ((x & 32'h1) != 0 ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_encode(input logic [31:0] x);
        logic [31:0] imm, f3;
        imm = x >> 20;
        f3  = (x >> 12) & 32'h7;
        if (f3 == 5) imm = imm & 32'h41F;
        if (f3 == 1) imm = imm & 32'h01F;
        return (imm << 20) | (x & 32'h000F_FF80) | 32'h13;
    endfunction

    logic [31:0] seq [SEQ_LEN];

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        done;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];

    // Model of the main instance.
    bit          m_run;
    bit          m_done;
    bit          m_valid;
    int          m_idx;
    int unsigned m_cnt;
    logic [31:0] m_instr;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_valid = 0; m_idx = 0; m_cnt = 0; m_instr = NOP;
    endtask

    // Called at posedge+1: drive inputs for the next edge, then model that edge.
    task automatic step(input bit st, input bit sl);
        exp_t e;
        start_a = st;
        stall_a = sl;
        @(posedge clk);
        #1;
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_cnt = 0; m_done = 0;
            end
        end else if (!sl) begin
            if (m_cnt < NI) begin
                m_instr = seq[m_idx];
                m_idx++;
                m_valid = 1;
                m_cnt++;
            end else begin
                m_run = 0; m_done = 1; m_valid = 0; m_instr = NOP;
            end
        end
        e.instr = m_instr; e.valid = m_valid; e.done = m_done; e.count = m_cnt;
        sb.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check32("sb_instr", instr_a, e.instr);
            check32("sb_valid", {31'b0, valid_a}, {31'b0, e.valid});
            check32("sb_done", {31'b0, done_a}, {31'b0, e.done});
            check32("sb_count", count_a, e.count);
        end
    end

    // Directed checks on the single-instruction and zero-instruction instances.
    initial begin
        start_b = 1'b0;
        start_c = 1'b0;
        wait (reset_n === 1'b1);
        @(posedge clk); #1;
        start_b = 1'b1; start_c = 1'b1;
        @(posedge clk); #1;                  // edge N: both enter run
        start_b = 1'b0; start_c = 1'b0;
        check32("b_valid_n", {31'b0, valid_b}, 32'd0);
        check32("c_done_n", {31'b0, done_c}, 32'd0);
        @(posedge clk); #1;                  // edge N+1
        // srai x31,x30,31 with imm 0xFFF masked to 0x41F
        check32("b_instr", instr_b, 32'h41FF_5F93);
        check32("b_valid", {31'b0, valid_b}, 32'd1);
        check32("b_count", count_b, 32'd1);
        check32("c_done", {31'b0, done_c}, 32'd1);
        check32("c_valid", {31'b0, valid_c}, 32'd0);
        check32("c_count", count_c, 32'd0);
        @(posedge clk); #1;                  // edge N+2
        check32("b_done", {31'b0, done_b}, 32'd1);
        check32("b_valid_end", {31'b0, valid_b}, 32'd0);
        check32("b_instr_end", instr_b, NOP);
        start_c = 1'b1;
        @(posedge clk); #1;                  // restart from done
        start_c = 1'b0;
        check32("c_restart_done", {31'b0, done_c}, 32'd0);
        check32("c_restart_count", count_c, 32'd0);
        @(posedge clk); #1;
        check32("c_done2", {31'b0, done_c}, 32'd1);
        check32("c_valid2", {31'b0, valid_c}, 32'd0);
        check32("c_instr2", instr_c, NOP);
    end

    initial begin
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < SEQ_LEN; i++) begin
            seq[i] = ref_encode(s);
            s = ref_lfsr_step(s);
        end
        model_reset();
        reset_n = 1'b0;
        start_a = 1'b0;
        stall_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_instr", instr_a, NOP);
        check32("rst_valid", {31'b0, valid_a}, 32'd0);
        check32("rst_count", count_a, 32'd0);
        reset_n = 1'b1;

        repeat (5) step(0, 0);               // idle holds NOP
        // Run with a 4-cycle stall after the first instruction appears.
        step(1, 0);
        step(0, 0);
        repeat (4) step(0, 1);
        repeat (6) step(0, 0);
        // Restart from done continues the sequence.
        step(1, 0);
        repeat (6) step(0, 0);
        // Asynchronous reset with count=2, away from any clock edge.
        step(1, 0);
        step(0, 0);
        step(0, 0);
        #5;
        reset_n = 1'b0;
        #1;
        check32("arst_instr", instr_a, NOP);
        check32("arst_valid", {31'b0, valid_a}, 32'd0);
        check32("arst_count", count_a, 32'd0);
        check32("arst_done", {31'b0, done_a}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        check32("arst_hold_count", count_a, 32'd0);
        reset_n = 1'b1;
        // Replays from the seed.
        step(1, 0);
        repeat (6) step(0, 0);
        // Randomised start/stall traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        repeat (3) step(0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
